// File: rtl/tlb.sv
// 16-entry fully associative LoongArch TLB: two combinational lookup ports,
// a combinational read port, and clocked write/INVTLB updates.
module tlb #(
  parameter int TLBNUM     = 16,
  parameter int LOG2TLBNUM = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  // lookup port 0 (fetch)
  input  logic [18:0]           s0_vppn,
  input  logic                  s0_va_bit12,
  input  logic [9:0]            s0_asid,
  output logic                  s0_found,
  output logic [LOG2TLBNUM-1:0] s0_index,
  output logic [19:0]           s0_ppn,
  output logic [5:0]            s0_ps,
  output logic [1:0]            s0_plv,
  output logic [1:0]            s0_mat,
  output logic                  s0_d,
  output logic                  s0_v,
  // lookup port 1 (data access / TLBSRCH)
  input  logic [18:0]           s1_vppn,
  input  logic                  s1_va_bit12,
  input  logic [9:0]            s1_asid,
  output logic                  s1_found,
  output logic [LOG2TLBNUM-1:0] s1_index,
  output logic [19:0]           s1_ppn,
  output logic [5:0]            s1_ps,
  output logic [1:0]            s1_plv,
  output logic [1:0]            s1_mat,
  output logic                  s1_d,
  output logic                  s1_v,
  // invalidation
  input  logic                  invtlb_valid,
  input  logic [4:0]            invtlb_op,
  input  logic [9:0]            invtlb_asid,
  input  logic [18:0]           invtlb_vppn,
  // write port
  input  logic                  we,
  input  logic [LOG2TLBNUM-1:0] w_index,
  input  logic                  w_e,
  input  logic [18:0]           w_vppn,
  input  logic [5:0]            w_ps,
  input  logic [9:0]            w_asid,
  input  logic                  w_g,
  input  logic [19:0]           w_ppn0,
  input  logic [1:0]            w_plv0,
  input  logic [1:0]            w_mat0,
  input  logic                  w_d0,
  input  logic                  w_v0,
  input  logic [19:0]           w_ppn1,
  input  logic [1:0]            w_plv1,
  input  logic [1:0]            w_mat1,
  input  logic                  w_d1,
  input  logic                  w_v1,
  // read port
  input  logic [LOG2TLBNUM-1:0] r_index,
  output logic                  r_e,
  output logic [18:0]           r_vppn,
  output logic [5:0]            r_ps,
  output logic [9:0]            r_asid,
  output logic                  r_g,
  output logic [19:0]           r_ppn0,
  output logic [1:0]            r_plv0,
  output logic [1:0]            r_mat0,
  output logic                  r_d0,
  output logic                  r_v0,
  output logic [19:0]           r_ppn1,
  output logic [1:0]            r_plv1,
  output logic [1:0]            r_mat1,
  output logic                  r_d1,
  output logic                  r_v1
);

  // No handshake anywhere: we and invtlb_valid are single-cycle pulses that are
  // always accepted at the next posedge; lookups and reads never stall.

  typedef struct packed {
    logic        e;
    logic        g;
    logic [18:0] vppn;
    logic [5:0]  ps;
    logic [9:0]  asid;
    logic [19:0] ppn0;
    logic [1:0]  plv0;
    logic [1:0]  mat0;
    logic        d0;
    logic        v0;
    logic [19:0] ppn1;
    logic [1:0]  plv1;
    logic [1:0]  mat1;
    logic        d1;
    logic        v1;
  } entry_t;

  typedef struct packed {
    logic                  found;
    logic [LOG2TLBNUM-1:0] index;
    logic [19:0]           ppn;
    logic [5:0]            ps;
    logic [1:0]            plv;
    logic [1:0]            mat;
    logic                  d;
    logic                  v;
  } lk_res_t;

  entry_t tlb_q [TLBNUM];
  entry_t w_ent;
  lk_res_t s0_res, s1_res;
  logic [TLBNUM-1:0] inv_sel;

  // PS==21 is a 2 MB page (4 MB pair); every other PS value behaves as 4 KB.
  function automatic logic vppn_match(input logic [18:0] va, input logic [18:0] ent,
                                      input logic [5:0] ps);
    if (ps == 6'd21) return va[18:9] == ent[18:9];
    return va == ent;
  endfunction

  function automatic logic page_odd(input logic [18:0] va, input logic bit12,
                                    input logic [5:0] ps);
    return (ps == 6'd21) ? va[8] : bit12;
  endfunction

  // Scan from the top so the lowest matching index overwrites everything last.
  function automatic lk_res_t lookup(input entry_t tab [TLBNUM], input logic [18:0] va,
                                     input logic bit12, input logic [9:0] asid);
    lk_res_t res;
    res = '0;
    for (int i = TLBNUM - 1; i >= 0; i--) begin
      if (tab[i].e && (tab[i].g || tab[i].asid == asid) &&
          vppn_match(va, tab[i].vppn, tab[i].ps)) begin
        res.found = 1'b1;
        res.index = LOG2TLBNUM'(i);
        res.ps    = tab[i].ps;
        if (page_odd(va, bit12, tab[i].ps)) begin
          res.ppn = tab[i].ppn1; res.plv = tab[i].plv1; res.mat = tab[i].mat1;
          res.d   = tab[i].d1;   res.v   = tab[i].v1;
        end else begin
          res.ppn = tab[i].ppn0; res.plv = tab[i].plv0; res.mat = tab[i].mat0;
          res.d   = tab[i].d0;   res.v   = tab[i].v0;
        end
      end
    end
    return res;
  endfunction

  always_comb begin
    s0_res = lookup(tlb_q, s0_vppn, s0_va_bit12, s0_asid);
    s1_res = lookup(tlb_q, s1_vppn, s1_va_bit12, s1_asid);
  end

  assign {s0_found, s0_index, s0_ppn, s0_ps, s0_plv, s0_mat, s0_d, s0_v} = s0_res;
  assign {s1_found, s1_index, s1_ppn, s1_ps, s1_plv, s1_mat, s1_d, s1_v} = s1_res;

  always_comb begin
    inv_sel = '0;
    for (int i = 0; i < TLBNUM; i++) begin
      case (invtlb_op)
        5'd0, 5'd1: inv_sel[i] = 1'b1;
        5'd2:       inv_sel[i] = tlb_q[i].g;
        5'd3:       inv_sel[i] = !tlb_q[i].g;
        5'd4:       inv_sel[i] = !tlb_q[i].g && (tlb_q[i].asid == invtlb_asid);
        5'd5:       inv_sel[i] = !tlb_q[i].g && (tlb_q[i].asid == invtlb_asid) &&
                                 vppn_match(invtlb_vppn, tlb_q[i].vppn, tlb_q[i].ps);
        5'd6:       inv_sel[i] = (tlb_q[i].g || (tlb_q[i].asid == invtlb_asid)) &&
                                 vppn_match(invtlb_vppn, tlb_q[i].vppn, tlb_q[i].ps);
        default:    inv_sel[i] = 1'b0;
      endcase
    end
  end

  assign w_ent = '{e: w_e, g: w_g, vppn: w_vppn, ps: w_ps, asid: w_asid,
                   ppn0: w_ppn0, plv0: w_plv0, mat0: w_mat0, d0: w_d0, v0: w_v0,
                   ppn1: w_ppn1, plv1: w_plv1, mat1: w_mat1, d1: w_d1, v1: w_v1};

  // The write is issued after the invalidation so a same-cycle write wins its entry.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < TLBNUM; i++) tlb_q[i] <= '0;
    end else begin
      if (invtlb_valid) begin
        for (int i = 0; i < TLBNUM; i++) begin
          if (inv_sel[i]) tlb_q[i].e <= 1'b0;
        end
      end
      if (we) tlb_q[w_index] <= w_ent;
    end
  end

  assign {r_e, r_g, r_vppn, r_ps, r_asid, r_ppn0, r_plv0, r_mat0, r_d0, r_v0,
          r_ppn1, r_plv1, r_mat1, r_d1, r_v1} = tlb_q[r_index];

endmodule
